htif_loader: RTL and testbench

//  Host-target interface loader directly upstream of the scratchpad memory.

---
 rtl/htif_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_htif_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htif_loader.sv
// htif_loader: byte-serial host command parser driving one scratchpad word port.
// The host streams WRITE/READ/RUN/HALT packets. The loader turns them into
// single-cycle word requests and holds the core in reset until RUN.
module htif_loader #(
  parameter int AW = 32,  // byte address width; the header carries 4 address bytes
  parameter int DW = 32   // word width; fixed at 4 bytes
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          mem_req_valid,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_data,
  output logic          mem_req_fcn,
  output logic [2:0]    mem_req_typ,
  input  logic [DW-1:0] mem_resp_data,
  output logic          core_rst,
  output logic          err,
  output logic [3:0]    dbg_state
);

  // Handshake: a byte moves on rx (or tx) exactly at a posedge where valid and
  // ready are both 1. A producer holds valid and data stable until that edge.
  // The loader never lowers tx_valid or changes tx_data while waiting for tx_ready.

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;
  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NAK  = 8'h5A;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_CNT   = 4'd2,
    S_WDATA = 4'd3,
    S_WRITE = 4'd4,
    S_RDATA = 4'd5,
    S_TXW   = 4'd6,
    S_ACK   = 4'd7
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr_asm;
  logic [DW-1:0] word_q, word_d;
  logic [8:0]    cnt_q, cnt_d;       // words remaining, 1..256
  logic [1:0]    idx_q, idx_d;       // byte position within address or word
  logic          is_wr_q, is_wr_d;
  logic [7:0]    resp_q, resp_d;     // byte sent in ACK state: ACK or NAK
  logic          core_rst_q, core_rst_d;
  logic          err_q, err_d;
  logic          ready_en_q;         // keeps rx_ready low for the first cycle out of reset

  logic          rx_fire;
  logic          tx_fire;
  logic          last_word;

  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign last_word = (cnt_q == 9'd1);
  // Address bytes arrive LSB first; each new byte enters at the top and shifts down.
  assign addr_asm  = {rx_data, addr_q[AW-1:8]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          // WRITE/READ are only honoured while the core is held; everything else answers at once.
          if ((rx_data == CMD_WRITE || rx_data == CMD_READ) && core_rst_q) state_d = S_ADDR;
          else                                                             state_d = S_ACK;
        end
      end
      S_ADDR:  if (rx_fire && idx_q == 2'd3) state_d = S_CNT;
      S_CNT:   if (rx_fire) state_d = is_wr_q ? S_WDATA : S_RDATA;
      S_WDATA: if (rx_fire && idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_ACK : S_WDATA;
      S_RDATA: state_d = S_TXW;
      S_TXW:   if (tx_fire && idx_q == 2'd3) state_d = last_word ? S_ACK : S_RDATA;
      S_ACK:   if (tx_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    rx_ready      = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    mem_req_valid = 1'b0;
    mem_req_fcn   = 1'b0;
    unique case (state_q)
      S_IDLE, S_ADDR, S_CNT, S_WDATA: rx_ready = ready_en_q;
      S_WRITE: begin
        // Memory belongs to the core once it runs, so requests are gated by core_rst.
        mem_req_valid = core_rst_q;
        mem_req_fcn   = core_rst_q;
      end
      S_RDATA: mem_req_valid = core_rst_q;
      S_TXW: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
      end
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = resp_q;
      end
      default: ;
    endcase
  end

  assign mem_req_addr = addr_q;
  assign mem_req_data = word_q;
  assign mem_req_typ  = 3'd3;
  assign core_rst     = core_rst_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

  // Datapath next values: address/count parsing, word assembly and shifting, flags
  always_comb begin
    addr_d     = addr_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    is_wr_d    = is_wr_q;
    resp_d     = resp_q;
    core_rst_d = core_rst_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          idx_d   = 2'd0;
          is_wr_d = (rx_data == CMD_WRITE);
          resp_d  = RESP_ACK;
          unique case (rx_data)
            CMD_WRITE, CMD_READ: begin
              if (!core_rst_q) begin
                resp_d = RESP_NAK;
                err_d  = 1'b1;
              end
            end
            CMD_RUN:  core_rst_d = 1'b0;
            CMD_HALT: core_rst_d = 1'b1;
            default: begin
              resp_d = RESP_NAK;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          // The final byte completes the address; word alignment is enforced then.
          if (idx_q == 2'd3) addr_d = {addr_asm[AW-1:2], 2'b00};
          else               addr_d = addr_asm;
          idx_d = idx_q + 2'd1;
        end
      end
      S_CNT: begin
        if (rx_fire) begin
          cnt_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          idx_d = 2'd0;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          word_d = {rx_data, word_q[DW-1:8]};
          idx_d  = idx_q + 2'd1;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + AW'(4);
        cnt_d  = cnt_q - 9'd1;
      end
      S_RDATA: begin
        word_d = mem_resp_data;
        idx_d  = 2'd0;
      end
      S_TXW: begin
        if (tx_fire) begin
          word_d = {8'h00, word_q[DW-1:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d = addr_q + AW'(4);
            cnt_d  = cnt_q - 9'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      word_q     <= '0;
      cnt_q      <= 9'd0;
      idx_q      <= 2'd0;
      is_wr_q    <= 1'b0;
      resp_q     <= RESP_ACK;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      is_wr_q    <= is_wr_d;
      resp_q     <= resp_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_htif_loader.sv
// Bench for htif_loader: random host packets against a packet-level reference
// model, a scratchpad memory attached to the port and expected-value queues.
`timescale 1ns/1ps
module tb_htif_loader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [7:0] ACK_B = 8'hA5;
  localparam logic [7:0] NAK_B = 8'h5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_req_fcn;
  logic [2:0]    mem_req_typ;
  logic [DW-1:0] mem_resp_data = '0;
  logic          core_rst;
  logic          err;
  logic [3:0]    dbg_state;

  htif_loader #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_fcn   (mem_req_fcn),
    .mem_req_typ   (mem_req_typ),
    .mem_resp_data (mem_resp_data),
    .core_rst      (core_rst),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [71:0] exp_wr_q[$];   // {8'h00, addr, data} of each expected write
  logic [31:0] exp_rd_q[$];   // expected read addresses
  logic [7:0]  exp_tx_q[$];   // expected response bytes
  logic [31:0] pkt_words[$];  // write payload of the packet being sent

  logic [31:0] sp_mem[logic [31:0]];   // scratchpad seen by the DUT
  logic [31:0] ref_mem[logic [31:0]];  // model's view of memory

  bit m_halted = 1'b1;
  bit m_err    = 1'b0;
  int tx_mode  = 0;  // 0: random tx_ready, 1: toggle every cycle

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pat(a);
  endfunction

  // ---------------- scratchpad ----------------
  always @(posedge clk) begin
    if (mem_req_valid === 1'b1 && mem_req_fcn === 1'b1) sp_mem[mem_req_addr] = mem_req_data;
  end

  // ---------------- monitor (samples on negedge) ----------------
  always @(negedge clk) begin
    if (!$isunknown(mem_req_addr)) begin
      if (sp_mem.exists(mem_req_addr)) mem_resp_data = sp_mem[mem_req_addr];
      else                             mem_resp_data = init_pat(mem_req_addr);
    end
    if (mem_req_valid === 1'b1 && mem_req_fcn === 1'b1) begin
      check("wr", {8'h00, mem_req_addr, mem_req_data},
            (exp_wr_q.size() != 0) ? exp_wr_q[0] : {8'hFF, 64'h0});
      check("wr_typ", 72'(mem_req_typ), 72'(3));
      check("wr_rx_ready", 72'(rx_ready), 72'(0));
      if (exp_wr_q.size() != 0) void'(exp_wr_q.pop_front());
    end
    if (mem_req_valid === 1'b1 && mem_req_fcn === 1'b0) begin
      check("rd_addr", {40'h0, mem_req_addr},
            (exp_rd_q.size() != 0) ? {40'h0, exp_rd_q[0]} : {40'hFF, 32'h0});
      if (exp_rd_q.size() != 0) void'(exp_rd_q.pop_front());
    end
    if (core_rst === 1'b0) check("mem_owner", 72'(mem_req_valid), 72'(0));
    if (tx_valid === 1'b1) begin
      check("tx_byte", 72'({1'b0, tx_data}),
            (exp_tx_q.size() != 0) ? 72'({1'b0, exp_tx_q[0]}) : 72'(9'h100));
      check("tx_rx_ready", 72'(rx_ready), 72'(0));
      if (tx_ready && exp_tx_q.size() != 0) void'(exp_tx_q.pop_front());
    end
  end

  // ---------------- tx_ready driver ----------------
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_mode == 1) tx_ready = ~tx_ready;
      else              tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_pkt(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] cnt);
    int n;
    logic [31:0] base, a, w;
    n    = (cnt == 8'h00) ? 256 : int'(cnt);
    base = addr & 32'hFFFF_FFFC;
    case (cmd)
      8'h01, 8'h02: begin
        if (!m_halted) begin
          exp_tx_q.push_back(NAK_B);
          m_err = 1'b1;
        end else begin
          for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            if (cmd == 8'h01) begin
              w = pkt_words[i];
              ref_mem[a] = w;
              exp_wr_q.push_back({8'h00, a, w});
            end else begin
              w = ref_rd(a);
              exp_rd_q.push_back(a);
              for (int b = 0; b < 4; b++) exp_tx_q.push_back(w[8*b +: 8]);
            end
          end
          exp_tx_q.push_back(ACK_B);
        end
      end
      8'h03: begin m_halted = 1'b0; exp_tx_q.push_back(ACK_B); end
      8'h04: begin m_halted = 1'b1; exp_tx_q.push_back(ACK_B); end
      default: begin
        exp_tx_q.push_back(NAK_B);
        m_err = 1'b1;
      end
    endcase
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 1);
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        return;
      end
    end
    check("rx_timeout", 72'(rx_ready), 72'(1));
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_tx_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("tx_drain", 72'(exp_tx_q.size()), 72'(0));
    @(posedge clk);
    #1;
    check("wr_drain", 72'(exp_wr_q.size()), 72'(0));
    check("rd_drain", 72'(exp_rd_q.size()), 72'(0));
    check("core_rst", 72'(core_rst), 72'(m_halted));
    check("err", 72'(err), 72'(m_err));
  endtask

  task automatic run_pkt(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] cnt,
                         input bit lat_chk);
    bit hdr;
    int n;
    logic [31:0] w;
    hdr = ((cmd == 8'h01) || (cmd == 8'h02)) && m_halted;
    n   = (cnt == 8'h00) ? 256 : int'(cnt);
    model_pkt(cmd, addr, cnt);
    send_byte(cmd);
    if (hdr) begin
      for (int b = 0; b < 4; b++) send_byte(addr[8*b +: 8]);
      send_byte(cnt);
      if (cmd == 8'h02 && lat_chk) begin
        @(negedge clk);
        check("rd_lat_req", 72'({mem_req_valid, mem_req_fcn, tx_valid}), 72'(3'b100));
        @(negedge clk);
        check("rd_lat_tx", 72'(tx_valid), 72'(1));
        @(posedge clk);
        #1;
      end
      if (cmd == 8'h01) begin
        for (int i = 0; i < n; i++) begin
          w = pkt_words[i];
          for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
          if (lat_chk) begin
            @(negedge clk);
            check("wr_lat", 72'({mem_req_valid, mem_req_fcn}), 72'(2'b11));
            @(posedge clk);
            #1;
          end
        end
      end
    end
    wait_done();
    pkt_words.delete();
  endtask

  task automatic fill_words(input int n);
    pkt_words.delete();
    for (int i = 0; i < n; i++) pkt_words.push_back($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [7:0]  c;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_rst", 72'(core_rst), 72'(1));
    check("rst_tx_valid", 72'(tx_valid), 72'(0));
    check("rst_mem_valid", 72'(mem_req_valid), 72'(0));
    check("rst_mem_fcn", 72'(mem_req_fcn), 72'(0));
    check("rst_err", 72'(err), 72'(0));
    check("rst_rx_ready", 72'(rx_ready), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_first", 72'(rx_ready), 72'(0));
    @(negedge clk);
    check("rx_ready_second", 72'(rx_ready), 72'(1));
    @(posedge clk);
    #1;

    // Directed write then read with tx_ready toggling
    pkt_words = '{32'h1234_5678, 32'hDEAD_BEEF};
    run_pkt(8'h01, 32'h0000_0010, 8'd2, 1'b1);
    tx_mode = 1;
    run_pkt(8'h02, 32'h0000_0010, 8'd2, 1'b1);
    tx_mode = 0;

    // Misaligned address is aligned down
    pkt_words = '{32'hCAFE_F00D};
    run_pkt(8'h01, 32'h0000_0013, 8'd1, 1'b0);
    run_pkt(8'h02, 32'h0000_0010, 8'd2, 1'b0);

    // Address wrap
    fill_words(2);
    run_pkt(8'h01, 32'hFFFF_FFFC, 8'd2, 1'b0);
    run_pkt(8'h02, 32'hFFFF_FFFE, 8'd2, 1'b0);

    // CNT 0 means 256 words
    fill_words(256);
    run_pkt(8'h01, 32'h0000_1000, 8'd0, 1'b0);
    run_pkt(8'h02, 32'h0000_13F8, 8'd4, 1'b0);

    // Random traffic over a small overlapping window
    for (int k = 0; k < 12; k++) begin
      a = 32'h0000_2000 + 32'($urandom_range(0, 127));
      c = 8'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        fill_words(int'(c));
        run_pkt(8'h01, a, c, 1'b0);
      end else begin
        run_pkt(8'h02, a, c, 1'b0);
      end
    end

    // Run control and memory ownership
    run_pkt(8'h03, 32'h0, 8'h0, 1'b0);
    fill_words(1);
    run_pkt(8'h01, 32'h0000_0010, 8'd1, 1'b0);
    run_pkt(8'h02, 32'h0000_0010, 8'd1, 1'b0);
    run_pkt(8'h03, 32'h0, 8'h0, 1'b0);
    run_pkt(8'h04, 32'h0, 8'h0, 1'b0);
    run_pkt(8'h04, 32'h0, 8'h0, 1'b0);

    // Reset in the middle of a write packet
    send_byte(8'h01);
    for (int b = 0; b < 4; b++) send_byte(8'(b == 0 ? 8'h10 : 8'h00));
    send_byte(8'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    m_err    = 1'b0;
    m_halted = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_err", 72'(err), 72'(0));
    check("mid_rst_core", 72'(core_rst), 72'(1));
    check("mid_rst_tx", 72'(tx_valid), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    run_pkt(8'h02, 32'h0000_0010, 8'd2, 1'b0);

    // Unknown commands
    run_pkt(8'h7F, 32'h0, 8'h0, 1'b0);
    run_pkt(8'h00, 32'h0, 8'h0, 1'b0);
    fill_words(1);
    run_pkt(8'h01, 32'h0000_0020, 8'd1, 1'b0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
